dffre_pipe: RTL and testbench

- Parametrised successor of the single-bit enabled/reset flop: a WIDTH-bit, DEPTH-stage register pipeline with a per-stage valid tag, synchronous clear and occupancy count.
- Two modes: lockstep shift, where the global enable stalls every stage, and elastic, where bubbles collapse and i_Enable acts as downstream ready.
- Used as a configurable retiming/skid stage between fabric blocks and as the architecture benchmark for enable/reset flop packing.

---
 rtl/dffre_pipe_if.sv | 38 +++
 rtl/dffre_pipe.sv | 78 +++++++
 tb/tb_dffre_pipe.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dffre_pipe_if.sv
// rtl/dffre_pipe_if.sv - handshake/data bundle for the dffre_pipe register pipeline
//
// Purpose: groups the per-word control, data and status signals of dffre_pipe.
// Ports (signals):
//   i_Enable  shift enable (lockstep) or downstream ready (elastic)
//   i_Clear   synchronous clear, wins over i_Enable
//   i_Valid   input word valid
//   i_D       input data, WIDTH bits
//   o_Ready   input accepted this cycle when i_Valid is also 1
//   o_Valid   valid tag of the last stage
//   o_Q       data of the last stage, WIDTH bits
//   o_Count   number of stages holding valid data
// Modports: master drives the inputs (upstream/downstream side), slave is the pipeline.
interface dffre_pipe_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             i_Enable;
  logic             i_Clear;
  logic             i_Valid;
  logic [WIDTH-1:0] i_D;
  logic             o_Ready;
  logic             o_Valid;
  logic [WIDTH-1:0] o_Q;
  logic [CW-1:0]    o_Count;

  modport master (
    output i_Enable, i_Clear, i_Valid, i_D,
    input  o_Ready, o_Valid, o_Q, o_Count
  );

  modport slave (
    input  i_Enable, i_Clear, i_Valid, i_D,
    output o_Ready, o_Valid, o_Q, o_Count
  );
endinterface

// File: rtl/dffre_pipe.sv
// rtl/dffre_pipe.sv - WIDTH x DEPTH enabled/cleared register pipeline, lockstep or elastic
//
// Purpose: multi-stage successor of the single enabled/reset flop. Each stage
// holds a data word and a valid tag. ELASTIC=0 shifts every stage together
// under i_Enable; ELASTIC=1 lets words advance into empty stages (bubble
// collapse) with i_Enable acting as downstream ready.
// Ports:
//   clk      rising-edge clock
//   i_Reset  asynchronous active-low reset, released synchronously by the user
//   bus      dffre_pipe_if slave: i_Enable, i_Clear, i_Valid, i_D in;
//            o_Ready, o_Valid, o_Q, o_Count out
module dffre_pipe #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               ELASTIC   = 0
) (
  input  logic         clk,
  input  logic         i_Reset,
  dffre_pipe_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data_r [DEPTH];
  logic [DEPTH-1:0] vld_r;

  // go[k]=1 means stage k loads from its upstream neighbour this edge.
  // go[DEPTH] is the downstream ready. In elastic mode a stage may load when it
  // is empty or when the stage ahead of it is itself moving; the chain runs
  // from the output back to the input within one cycle. In lockstep mode the
  // chain simply copies i_Enable to every stage.
  logic [DEPTH:0] go;

  always_comb begin
    go        = '0;
    go[DEPTH] = bus.i_Enable;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (ELASTIC != 0) begin
        go[k] = !vld_r[k] || go[k+1];
      end else begin
        go[k] = go[k+1];
      end
    end
  end

  always_ff @(posedge clk or negedge i_Reset) begin
    if (!i_Reset) begin
      vld_r <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        data_r[k] <= RESET_VAL;
      end
    end else if (bus.i_Clear) begin
      // Clear drops the word presented this cycle as well as everything in flight.
      vld_r <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        data_r[k] <= RESET_VAL;
      end
    end else begin
      // Stage 0 loads the input word even when i_Valid=0 so that lockstep
      // bubbles carry i_D unchanged.
      if (go[0]) begin
        vld_r[0]  <= bus.i_Valid;
        data_r[0] <= bus.i_D;
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (go[k]) begin
          vld_r[k]  <= vld_r[k-1];
          data_r[k] <= data_r[k-1];
        end
      end
    end
  end

  assign bus.o_Ready = go[0];
  assign bus.o_Valid = vld_r[DEPTH-1];
  assign bus.o_Q     = data_r[DEPTH-1];
  assign bus.o_Count = CW'($countones(vld_r));
endmodule

// File: tb/tb_dffre_pipe.sv
// tb/tb_dffre_pipe.sv - directed and soak bench for dffre_pipe in both modes
module tb_dffre_pipe;
  localparam int NI = 6;
  localparam int W [NI] = '{8, 8, 1, 8, 1, 1};
  localparam int D [NI] = '{4, 4, 1, 3, 3, 1};
  localparam int E [NI] = '{0, 1, 0, 1, 0, 1};
  localparam logic [7:0] RV [NI] = '{8'hA5, 8'hA5, 8'h01, 8'h5A, 8'h00, 8'h01};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic       vld = 1'b0;
  logic [7:0] d = 8'h00;

  logic [7:0] q_arr   [NI];
  logic       v_arr   [NI];
  logic       rdy_arr [NI];
  logic [3:0] cnt_arr [NI];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_inst
    dffre_pipe_if #(.WIDTH(W[g]), .DEPTH(D[g])) bus ();
    assign bus.i_Enable = en;
    assign bus.i_Clear  = clr;
    assign bus.i_Valid  = vld;
    assign bus.i_D      = d[W[g]-1:0];
    dffre_pipe #(
      .WIDTH(W[g]), .DEPTH(D[g]), .RESET_VAL(RV[g][W[g]-1:0]), .ELASTIC(E[g])
    ) u_dut (
      .clk(clk), .i_Reset(rst_n), .bus(bus)
    );
    assign q_arr[g]   = 8'(bus.o_Q);
    assign v_arr[g]   = bus.o_Valid;
    assign rdy_arr[g] = bus.o_Ready;
    assign cnt_arr[g] = 4'(bus.o_Count);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; vld = 1'b0; d = 8'h00;
    tick(); tick();
    rst_n = 1'b1;
    en = 1'b1; vld = 1'b1; d = 8'h3C;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++; if (q_arr[i] !== 8'hA5) begin failures++; $display("FAIL reset_q inst=%0d got=%h exp=a5", i, q_arr[i]); end
      checks++; if (v_arr[i] !== 1'b0) begin failures++; $display("FAIL reset_valid inst=%0d got=%b exp=0", i, v_arr[i]); end
      checks++; if (cnt_arr[i] !== 4'd0) begin failures++; $display("FAIL reset_count inst=%0d got=%0d exp=0", i, cnt_arr[i]); end
    end
    rst_n = 1'b1;
    d = 8'h77; vld = 1'b1; en = 1'b1;
    tick();
    vld = 1'b0;
    tick(); tick();
    for (int i = 0; i < 2; i++) begin
      checks++; if (v_arr[i] !== 1'b0) begin failures++; $display("FAIL reset_early_valid inst=%0d got=%b exp=0", i, v_arr[i]); end
    end
    tick();
    for (int i = 0; i < 2; i++) begin
      checks++; if (v_arr[i] !== 1'b1 || q_arr[i] !== 8'h77) begin failures++; $display("FAIL reset_first_out inst=%0d got=%b/%h exp=1/77", i, v_arr[i], q_arr[i]); end
    end
  endtask

  task automatic test_lockstep();
    en = 1'b1;
    do_clear();
    for (int i = 1; i <= 4; i++) begin
      d = 8'(i); vld = 1'b1;
      tick();
    end
    checks++; if (v_arr[0] !== 1'b1 || q_arr[0] !== 8'h01) begin failures++; $display("FAIL lock_latency got=%b/%h exp=1/01", v_arr[0], q_arr[0]); end
    checks++; if (cnt_arr[0] !== 4'd4) begin failures++; $display("FAIL lock_full_count got=%0d exp=4", cnt_arr[0]); end
    vld = 1'b0; en = 1'b0; d = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (q_arr[0] !== 8'h01 || cnt_arr[0] !== 4'd4) begin failures++; $display("FAIL lock_stall cyc=%0d got=%h/%0d exp=01/4", i, q_arr[0], cnt_arr[0]); end
    end
    checks++; if (rdy_arr[0] !== 1'b0) begin failures++; $display("FAIL lock_ready_stall got=%b exp=0", rdy_arr[0]); end
    en = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      tick();
      checks++; if (v_arr[0] !== 1'b1 || q_arr[0] !== 8'(i)) begin failures++; $display("FAIL lock_resume got=%b/%h exp=1/%h", v_arr[0], q_arr[0], 8'(i)); end
    end
  endtask

  task automatic test_elastic_fill();
    en = 1'b0; vld = 1'b0;
    do_clear();
    for (int i = 0; i < 4; i++) begin
      d = 8'h10 + 8'(i); vld = 1'b1;
      tick();
    end
    checks++; if (cnt_arr[1] !== 4'd4) begin failures++; $display("FAIL fill_count got=%0d exp=4", cnt_arr[1]); end
    checks++; if (q_arr[1] !== 8'h10 || v_arr[1] !== 1'b1) begin failures++; $display("FAIL fill_head got=%b/%h exp=1/10", v_arr[1], q_arr[1]); end
    d = 8'h14; vld = 1'b1;
    #1;
    checks++; if (rdy_arr[1] !== 1'b0) begin failures++; $display("FAIL fill_ready_full got=%b exp=0", rdy_arr[1]); end
    tick();
    checks++; if (cnt_arr[1] !== 4'd4 || q_arr[1] !== 8'h10) begin failures++; $display("FAIL fill_reject got=%0d/%h exp=4/10", cnt_arr[1], q_arr[1]); end
    en = 1'b1;
    #1;
    checks++; if (rdy_arr[1] !== 1'b1) begin failures++; $display("FAIL fill_ready_drain got=%b exp=1", rdy_arr[1]); end
    tick();
    vld = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      checks++; if (v_arr[1] !== 1'b1 || q_arr[1] !== 8'h10 + 8'(i)) begin failures++; $display("FAIL fill_drain got=%b/%h exp=1/%h", v_arr[1], q_arr[1], 8'h10 + 8'(i)); end
      tick();
    end
    checks++; if (v_arr[1] !== 1'b0 || cnt_arr[1] !== 4'd0) begin failures++; $display("FAIL fill_empty got=%b/%0d exp=0/0", v_arr[1], cnt_arr[1]); end
  endtask

  task automatic test_bubble();
    en = 1'b0; vld = 1'b0;
    do_clear();
    d = 8'hAA; vld = 1'b1;
    tick();
    vld = 1'b0;
    tick(); tick();
    d = 8'hBB; vld = 1'b1;
    tick();
    vld = 1'b0;
    checks++; if (cnt_arr[1] !== 4'd2 || q_arr[1] !== 8'hAA) begin failures++; $display("FAIL bubble_count got=%0d/%h exp=2/aa", cnt_arr[1], q_arr[1]); end
    for (int i = 0; i < 3; i++) tick();
    checks++; if (cnt_arr[1] !== 4'd2 || q_arr[1] !== 8'hAA || v_arr[1] !== 1'b1) begin failures++; $display("FAIL bubble_hold got=%0d/%h exp=2/aa", cnt_arr[1], q_arr[1]); end
    en = 1'b1;
    tick();
    checks++; if (v_arr[1] !== 1'b1 || q_arr[1] !== 8'hBB) begin failures++; $display("FAIL bubble_adjacent got=%b/%h exp=1/bb", v_arr[1], q_arr[1]); end
    tick();
    checks++; if (v_arr[1] !== 1'b0) begin failures++; $display("FAIL bubble_drained got=%b exp=0", v_arr[1]); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q [$];
    en = 1'b0; vld = 1'b0;
    do_clear();
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom); vld = 1'b1;
      exp_q.push_back(d);
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      d = 8'($urandom); vld = 1'b1; en = 1'b1;
      #1;
      checks++; if (cnt_arr[1] !== 4'd4 || v_arr[1] !== 1'b1 || q_arr[1] !== exp_q[0]) begin failures++; $display("FAIL b2b_stream cyc=%0d got=%0d/%b/%h exp=4/1/%h", i, cnt_arr[1], v_arr[1], q_arr[1], exp_q[0]); end
      exp_q.push_back(d);
      tick();
      void'(exp_q.pop_front());
    end
    clr = 1'b1; en = 1'b1; vld = 1'b1;
    tick();
    clr = 1'b0; vld = 1'b0;
    checks++; if (cnt_arr[1] !== 4'd0 || q_arr[1] !== 8'hA5 || v_arr[1] !== 1'b0) begin failures++; $display("FAIL b2b_clear got=%0d/%h/%b exp=0/a5/0", cnt_arr[1], q_arr[1], v_arr[1]); end
  endtask

  task automatic test_soak();
    logic [7:0] md [NI][4];
    logic       mv [NI][4];
    logic [7:0] fq [NI][8];
    int         hd [NI];
    int         sz [NI];
    int         exp_cnt;
    logic       exp_v, exp_r;
    logic [7:0] exp_qv, mask;
    rst_n = 1'b0; clr = 1'b0; en = 1'b0; vld = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < NI; i++) begin
      mask = 8'((1 << W[i]) - 1);
      for (int k = 0; k < 4; k++) begin md[i][k] = RV[i] & mask; mv[i][k] = 1'b0; end
      hd[i] = 0; sz[i] = 0;
    end
    for (int c = 0; c < 1500; c++) begin
      en  = ($urandom_range(0, 3) != 0);
      vld = 1'($urandom_range(0, 1));
      d   = 8'($urandom);
      clr = ($urandom_range(0, 99) == 0);
      #1;
      for (int i = 0; i < NI; i++) begin
        if (E[i] == 0) begin
          exp_cnt = 0;
          for (int k = 0; k < D[i]; k++) if (mv[i][k]) exp_cnt++;
          exp_v = mv[i][D[i]-1]; exp_qv = md[i][D[i]-1]; exp_r = en;
        end else begin
          exp_cnt = sz[i]; exp_v = (sz[i] > 0); exp_qv = fq[i][hd[i]];
          exp_r = (sz[i] < D[i]) || en;
        end
        checks++; if (cnt_arr[i] !== 4'(exp_cnt)) begin failures++; $display("FAIL soak_count inst=%0d cyc=%0d got=%0d exp=%0d", i, c, cnt_arr[i], exp_cnt); end
        checks++; if (rdy_arr[i] !== exp_r) begin failures++; $display("FAIL soak_ready inst=%0d cyc=%0d got=%b exp=%b", i, c, rdy_arr[i], exp_r); end
        if (E[i] == 0) begin
          checks++; if (v_arr[i] !== exp_v || q_arr[i] !== exp_qv) begin failures++; $display("FAIL soak_lock_out inst=%0d cyc=%0d got=%b/%h exp=%b/%h", i, c, v_arr[i], q_arr[i], exp_v, exp_qv); end
        end else begin
          checks++; if (v_arr[i] === 1'b1 && !exp_v) begin failures++; $display("FAIL soak_phantom inst=%0d cyc=%0d got=valid exp=empty", i, c); end
          if (v_arr[i] === 1'b1 && exp_v) begin
            checks++; if (q_arr[i] !== exp_qv) begin failures++; $display("FAIL soak_order inst=%0d cyc=%0d got=%h exp=%h", i, c, q_arr[i], exp_qv); end
          end
        end
      end
      for (int i = 0; i < NI; i++) begin
        mask = 8'((1 << W[i]) - 1);
        if (clr) begin
          for (int k = 0; k < 4; k++) begin md[i][k] = RV[i] & mask; mv[i][k] = 1'b0; end
          hd[i] = 0; sz[i] = 0;
        end else if (E[i] == 0) begin
          if (en) begin
            for (int k = 3; k > 0; k--) begin md[i][k] = md[i][k-1]; mv[i][k] = mv[i][k-1]; end
            md[i][0] = d & mask; mv[i][0] = vld;
          end
        end else begin
          exp_r = (sz[i] < D[i]) || en;
          if (v_arr[i] === 1'b1 && en && sz[i] > 0) begin hd[i] = (hd[i] + 1) % 8; sz[i]--; end
          if (vld && exp_r) begin fq[i][(hd[i] + sz[i]) % 8] = d & mask; sz[i]++; end
        end
      end
      tick();
    end
    clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lockstep();
    test_elastic_fill();
    test_bubble();
    test_back_to_back();
    test_soak();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
